// File: rtl/gpsdo_pkg.sv
// gpsdo_pkg: shared types and constants for the GPSDO sequencing controller.
// Holds the state encoding, the interval-counter width and helpers that
// derive the accepted PPS period window from the nominal rate and tolerance.
package gpsdo_pkg;

  // Encodings are visible on the state port, so they are pinned explicitly.
  typedef enum logic [2:0] {
    ST_PREHEAT  = 3'd0,
    ST_WAIT_PPS = 3'd1,
    ST_COARSE   = 3'd2,
    ST_FINE     = 3'd3,
    ST_HOLDOVER = 3'd4
  } gpsdo_state_e;

  // Wide enough for a 10 MHz reference plus tolerance.
  localparam int CNT_W = 25;

  // Shortest period still accepted as a valid PPS interval.
  function automatic logic [CNT_W-1:0] period_lo(input int freq, input int tol);
    return CNT_W'(freq - tol);
  endfunction

  // Longest accepted period; also the interval-counter saturation point.
  function automatic logic [CNT_W-1:0] period_hi(input int freq, input int tol);
    return CNT_W'(freq + tol);
  endfunction

endpackage

// File: rtl/gpsdo_seq_ctrl_pps_qualifier.sv
// pps_qualifier: brings the asynchronous 1PPS into CLK_SYS, emits a one-cycle
// tick per rising edge, measures the tick-to-tick interval and flags each tick
// as valid (in window and armed) or raises a miss when the interval overruns.
module pps_qualifier
  import gpsdo_pkg::*;
#(
  parameter int CLK_FREQ = 10_000_000,
  parameter int PPS_TOL  = 100
) (
  input  logic CLK_SYS,
  input  logic CLK_RST,
  input  logic PPS_in,
  output logic pps_tick,
  output logic pps_valid,
  output logic pps_miss
);

  localparam logic [CNT_W-1:0] PER_LO  = period_lo(CLK_FREQ, PPS_TOL);
  localparam logic [CNT_W-1:0] CNT_MAX = period_hi(CLK_FREQ, PPS_TOL);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;

  // [0],[1]: metastability stages; [2]: previous level for edge detection.
  logic [2:0]       sync_reg;
  logic             tick_reg;
  logic             miss_reg;
  logic             armed_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] period;

  // Synchronize PPS_in and register the rising-edge pulse.
  always_ff @(posedge CLK_SYS) begin
    if (CLK_RST) begin
      sync_reg <= '0;
      tick_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[1:0], PPS_in};
      tick_reg <= sync_reg[1] & ~sync_reg[2];
    end
  end

  // Interval counter, one-shot miss on reaching the window top, and arming.
  always_ff @(posedge CLK_SYS) begin
    if (CLK_RST) begin
      cnt_reg   <= '0;
      miss_reg  <= 1'b0;
      armed_reg <= 1'b0;
    end else begin
      miss_reg <= !tick_reg && (cnt_reg == CNT_PRE);
      if (tick_reg)
        cnt_reg <= '0;
      else if (cnt_reg != CNT_MAX)
        cnt_reg <= cnt_reg + 1'b1;
      // A tick always re-arms, so the tick that follows a miss is only a
      // reference point and the one after it is the first measurable period.
      if (tick_reg)
        armed_reg <= 1'b1;
      else if (miss_reg)
        armed_reg <= 1'b0;
    end
  end

  assign period    = cnt_reg + 1'b1;
  assign pps_tick  = tick_reg;
  assign pps_miss  = miss_reg;
  assign pps_valid = tick_reg && armed_reg && !miss_reg &&
                     (period >= PER_LO) && (period <= CNT_MAX);

endmodule

// File: rtl/gpsdo_seq_ctrl.sv
// gpsdo_seq_ctrl: GPSDO sequencing controller. Waits for oven preheat,
// qualifies the 1PPS, walks the loop through coarse then fine discipline and
// raises locked once the phase stays in window.
// Build option GPSDO_HOLDOVER_EN: when defined, loss of PPS/fix enters a
// HOLDOVER state with the DAC frozen and a timeout back to WAIT_PPS; when
// undefined, loss drops straight back to WAIT_PPS and dac_hold stays 0.
module gpsdo_seq_ctrl
  import gpsdo_pkg::*;
#(
  parameter int CLK_FREQ     = 10_000_000,
  parameter int PPS_TOL      = 100,
  parameter int PPS_GOOD_CNT = 5,
  parameter int LOCK_CNT     = 10,
  parameter int HOLD_MAX_S   = 3600
) (
  input  logic       CLK_SYS,
  input  logic       CLK_RST,
  input  logic       Preheat_done,
  input  logic       PPS_in,
  input  logic       gps_fix,
  input  logic       coarse_done,
  input  logic       phase_ok,
  output logic       pps_tick,
  output logic       loop_en,
  output logic       fine_mode,
  output logic       dac_hold,
  output logic       locked,
  output logic [2:0] state
);

  localparam int GOOD_W = $clog2(PPS_GOOD_CNT + 1);
  localparam int LOCK_W = $clog2(LOCK_CNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(PPS_GOOD_CNT);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CNT);

  logic pps_valid;
  logic pps_miss;
  logic loss;
  logic requal;

  gpsdo_state_e      state_reg, state_next;
  logic [GOOD_W-1:0] good_cnt_reg, good_cnt_next;
  logic [LOCK_W-1:0] lock_cnt_reg, lock_cnt_next;
  logic              loop_en_reg;
  logic              fine_mode_reg;
  logic              locked_reg;

  pps_qualifier #(
    .CLK_FREQ (CLK_FREQ),
    .PPS_TOL  (PPS_TOL)
  ) u_pps_qualifier (
    .CLK_SYS   (CLK_SYS),
    .CLK_RST   (CLK_RST),
    .PPS_in    (PPS_in),
    .pps_tick  (pps_tick),
    .pps_valid (pps_valid),
    .pps_miss  (pps_miss)
  );

  // Any event that breaks the chain of good periods also drops the loop.
  assign loss = pps_miss || !gps_fix || (pps_tick && !pps_valid);

  // Consecutive-good-period counter; next value feeds the FSM so the state
  // moves on the same edge that registers the qualifying tick.
  always_comb begin
    good_cnt_next = good_cnt_reg;
    if (loss)
      good_cnt_next = '0;
    else if (pps_valid && (good_cnt_reg != GOOD_MAX))
      good_cnt_next = good_cnt_reg + 1'b1;
  end

  assign requal = (good_cnt_next == GOOD_MAX);

`ifdef GPSDO_HOLDOVER_EN
  localparam int SEC_W = $clog2(HOLD_MAX_S + 1);
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(CLK_FREQ - 1);
  localparam logic [SEC_W-1:0] SEC_LAST   = SEC_W'(HOLD_MAX_S - 1);

  logic             hold_fine_reg, hold_fine_next;
  logic             dac_hold_reg;
  logic [CNT_W-1:0] presc_reg;
  logic [SEC_W-1:0] sec_reg;
  logic             hold_timeout;

  assign hold_timeout = (presc_reg == PRESC_LAST) && (sec_reg == SEC_LAST);

  // Holdover seconds timer; held at zero outside HOLDOVER so every entry
  // starts a fresh count.
  always_ff @(posedge CLK_SYS) begin
    if (CLK_RST || (state_reg != ST_HOLDOVER)) begin
      presc_reg <= '0;
      sec_reg   <= '0;
    end else if (presc_reg == PRESC_LAST) begin
      presc_reg <= '0;
      sec_reg   <= sec_reg + 1'b1;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end
`endif

  // Next-state logic; in HOLDOVER a requalification beats the timeout.
  always_comb begin
    state_next = state_reg;
`ifdef GPSDO_HOLDOVER_EN
    hold_fine_next = hold_fine_reg;
`endif
    case (state_reg)
      ST_PREHEAT:  if (Preheat_done) state_next = ST_WAIT_PPS;
      ST_WAIT_PPS: if (requal) state_next = ST_COARSE;
      ST_COARSE: begin
        if (loss) begin
`ifdef GPSDO_HOLDOVER_EN
          state_next     = ST_HOLDOVER;
          hold_fine_next = 1'b0;
`else
          state_next     = ST_WAIT_PPS;
`endif
        end else if (coarse_done) begin
          state_next = ST_FINE;
        end
      end
      ST_FINE: begin
        if (loss) begin
`ifdef GPSDO_HOLDOVER_EN
          state_next     = ST_HOLDOVER;
          hold_fine_next = 1'b1;
`else
          state_next     = ST_WAIT_PPS;
`endif
        end
      end
`ifdef GPSDO_HOLDOVER_EN
      ST_HOLDOVER: begin
        if (requal)
          state_next = hold_fine_reg ? ST_FINE : ST_COARSE;
        else if (hold_timeout)
          state_next = ST_WAIT_PPS;
      end
`endif
      default: state_next = ST_PREHEAT;
    endcase
  end

  // Lock counter: runs on in-window phase ticks while staying in FINE.
  always_comb begin
    lock_cnt_next = lock_cnt_reg;
    if (state_next != ST_FINE)
      lock_cnt_next = '0;
    else if (pps_tick && (state_reg == ST_FINE)) begin
      if (!phase_ok)
        lock_cnt_next = '0;
      else if (lock_cnt_reg != LOCK_MAX)
        lock_cnt_next = lock_cnt_reg + 1'b1;
    end
  end

  // State, counters and outputs registered together from next-state values.
  always_ff @(posedge CLK_SYS) begin
    if (CLK_RST) begin
      state_reg     <= ST_PREHEAT;
      good_cnt_reg  <= '0;
      lock_cnt_reg  <= '0;
      loop_en_reg   <= 1'b0;
      fine_mode_reg <= 1'b0;
      locked_reg    <= 1'b0;
`ifdef GPSDO_HOLDOVER_EN
      hold_fine_reg <= 1'b0;
      dac_hold_reg  <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      good_cnt_reg <= good_cnt_next;
      lock_cnt_reg <= lock_cnt_next;
      loop_en_reg  <= (state_next == ST_COARSE) || (state_next == ST_FINE) ||
                      (state_next == ST_HOLDOVER);
`ifdef GPSDO_HOLDOVER_EN
      hold_fine_reg <= hold_fine_next;
      fine_mode_reg <= (state_next == ST_FINE) ||
                       ((state_next == ST_HOLDOVER) && hold_fine_next);
      dac_hold_reg  <= (state_next == ST_HOLDOVER);
`else
      fine_mode_reg <= (state_next == ST_FINE);
`endif
      locked_reg <= (state_next == ST_FINE) && (lock_cnt_next >= LOCK_MAX);
    end
  end

  assign state     = state_reg;
  assign loop_en   = loop_en_reg;
  assign fine_mode = fine_mode_reg;
  assign locked    = locked_reg;
`ifdef GPSDO_HOLDOVER_EN
  assign dac_hold  = dac_hold_reg;
`else
  assign dac_hold  = 1'b0;
`endif

endmodule

// File: tb/tb_gpsdo_seq_ctrl.sv
// tb_gpsdo_seq_ctrl: directed bench for gpsdo_seq_ctrl with CLK_FREQ=1000,
// PPS_TOL=2, PPS_GOOD_CNT=3, LOCK_CNT=4, HOLD_MAX_S=5. Expectations for loss
// events follow whether GPSDO_HOLDOVER_EN is defined.
module tb_gpsdo_seq_ctrl;

`ifdef GPSDO_HOLDOVER_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif
  localparam logic [31:0] LOSS_ST  = HOLD_EN ? 32'd4 : 32'd1;
  localparam logic [31:0] LOSS_LOOP = HOLD_EN ? 32'd1 : 32'd0;

  logic       CLK_SYS = 1'b0;
  logic       CLK_RST;
  logic       Preheat_done;
  logic       PPS_in;
  logic       gps_fix;
  logic       coarse_done;
  logic       phase_ok;
  logic       pps_tick;
  logic       loop_en;
  logic       fine_mode;
  logic       dac_hold;
  logic       locked;
  logic [2:0] state;

  int tests_run    = 0;
  int tests_failed = 0;

  gpsdo_seq_ctrl #(
    .CLK_FREQ     (1000),
    .PPS_TOL      (2),
    .PPS_GOOD_CNT (3),
    .LOCK_CNT     (4),
    .HOLD_MAX_S   (5)
  ) dut (
    .CLK_SYS      (CLK_SYS),
    .CLK_RST      (CLK_RST),
    .Preheat_done (Preheat_done),
    .PPS_in       (PPS_in),
    .gps_fix      (gps_fix),
    .coarse_done  (coarse_done),
    .phase_ok     (phase_ok),
    .pps_tick     (pps_tick),
    .loop_en      (loop_en),
    .fine_mode    (fine_mode),
    .dac_hold     (dac_hold),
    .locked       (locked),
    .state        (state)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK_SYS);
  endtask

  // Rising PPS edge now, next edge may follow p cycles later.
  task automatic pps_edge(input int p);
    PPS_in = 1'b1;
    wait_cyc(10);
    PPS_in = 1'b0;
    wait_cyc(p - 10);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    CLK_RST = 1'b1; Preheat_done = 1'b0; PPS_in = 1'b0;
    gps_fix = 1'b0; coarse_done = 1'b0; phase_ok = 1'b0;
    wait_cyc(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_loop_en", 32'(loop_en), 32'd0);
    chk("rst_fine_mode", 32'(fine_mode), 32'd0);
    chk("rst_dac_hold", 32'(dac_hold), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_pps_tick", 32'(pps_tick), 32'd0);

    // PPS edge to tick latency is three cycles, pulse is one cycle wide.
    CLK_RST = 1'b0;
    PPS_in  = 1'b1;
    wait_cyc(2); chk("tick_lat2", 32'(pps_tick), 32'd0);
    wait_cyc(1); chk("tick_lat3", 32'(pps_tick), 32'd1);
    wait_cyc(1); chk("tick_lat4", 32'(pps_tick), 32'd0);
    wait_cyc(6); PPS_in = 1'b0; wait_cyc(990);

    // Preheat: PPS running but state held.
    pps_edge(1000); pps_edge(1000);
    chk("preheat_hold", 32'(state), 32'd0);
    Preheat_done = 1'b1; gps_fix = 1'b1;
    wait_cyc(1);
    chk("preheat_exit", 32'(state), 32'd1);
    chk("wait_loop_en", 32'(loop_en), 32'd0);
    pps_edge(1000); pps_edge(1000);
    chk("qual_partial", 32'(state), 32'd1);
    pps_edge(1000); pps_edge(1000);
    chk("qual_coarse", 32'(state), 32'd2);
    chk("coarse_loop_en", 32'(loop_en), 32'd1);
    chk("coarse_fine_mode", 32'(fine_mode), 32'd0);
    chk("coarse_dac_hold", 32'(dac_hold), 32'd0);

    // Window edges: 998 and 1002 accepted, 997 rejected.
    pps_edge(998);  pps_edge(1002);
    chk("win_998", 32'(state), 32'd2);
    pps_edge(997);
    chk("win_1002", 32'(state), 32'd2);
    pps_edge(1000);
    chk("win_997", 32'(state), LOSS_ST);
    chk("win_997_loop", 32'(loop_en), LOSS_LOOP);
    chk("win_997_dac", 32'(dac_hold), 32'(HOLD_EN));
    pps_edge(1000); pps_edge(1000);
    chk("requal_wait", 32'(state), LOSS_ST);
    pps_edge(1000);
    chk("requal_done", 32'(state), 32'd2);

    // Overrun: miss fires when the counter reaches 1002.
    wait_cyc(6);
    chk("miss_pre", 32'(state), 32'd2);
    wait_cyc(1);
    chk("miss_1002", 32'(state), LOSS_ST);
    chk("miss_fine_mode", 32'(fine_mode), 32'd0);
    pps_edge(1000); pps_edge(1000); pps_edge(1000);
    chk("rearm_wait", 32'(state), LOSS_ST);
    pps_edge(1000);
    chk("rearm_done", 32'(state), 32'd2);

    // Coarse to fine, then lock.
    coarse_done = 1'b1;
    wait_cyc(1);
    chk("fine_state", 32'(state), 32'd3);
    chk("fine_mode", 32'(fine_mode), 32'd1);
    phase_ok = 1'b1;
    pps_edge(1000); pps_edge(1000); pps_edge(1000);
    chk("lock_3", 32'(locked), 32'd0);
    pps_edge(1000);
    chk("lock_4", 32'(locked), 32'd1);
    phase_ok = 1'b0;
    pps_edge(1000);
    chk("unlock", 32'(locked), 32'd0);
    chk("unlock_state", 32'(state), 32'd3);
    phase_ok = 1'b1;

    // PPS stops while in FINE.
    wait_cyc(6);
    chk("fine_miss_pre", 32'(state), 32'd3);
    wait_cyc(1);
    chk("fine_miss", 32'(state), LOSS_ST);
    chk("fine_miss_dac", 32'(dac_hold), 32'(HOLD_EN));
    chk("fine_miss_fm", 32'(fine_mode), 32'(HOLD_EN));
    chk("fine_miss_loop", 32'(loop_en), LOSS_LOOP);
    chk("fine_miss_lock", 32'(locked), 32'd0);

`ifdef GPSDO_HOLDOVER_EN
    pps_edge(1000); pps_edge(1000); pps_edge(1000);
    chk("hold_rearm", 32'(state), 32'd4);
    pps_edge(1000);
    chk("hold_exit", 32'(state), 32'd3);
    chk("hold_exit_dac", 32'(dac_hold), 32'd0);
    chk("hold_exit_fm", 32'(fine_mode), 32'd1);
    wait_cyc(7);
    chk("hold_reentry", 32'(state), 32'd4);
    wait_cyc(4999);
    chk("hold_pre_to", 32'(state), 32'd4);
    wait_cyc(1);
    chk("hold_timeout", 32'(state), 32'd1);
    chk("hold_to_loop", 32'(loop_en), 32'd0);
    chk("hold_to_dac", 32'(dac_hold), 32'd0);
`endif

    // gps_fix drops while in COARSE.
    coarse_done = 1'b0;
    pps_edge(1000); pps_edge(1000); pps_edge(1000); pps_edge(1000);
    chk("fix_requal", 32'(state), 32'd2);
    gps_fix = 1'b0;
    wait_cyc(1);
    chk("fix_drop", 32'(state), LOSS_ST);
    chk("fix_drop_loop", 32'(loop_en), LOSS_LOOP);
    chk("fix_drop_dac", 32'(dac_hold), 32'(HOLD_EN));
    chk("fix_drop_fm", 32'(fine_mode), 32'd0);

    // Reset mid-operation with preheat already complete.
    gps_fix = 1'b1;
    CLK_RST = 1'b1;
    wait_cyc(1);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_loop", 32'(loop_en), 32'd0);
    CLK_RST = 1'b0;
    wait_cyc(1);
    chk("midrst_preheat", 32'(state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
